// File: rtl/lfsr_prng.sv
// XNOR-feedback Fibonacci LFSR that packs OUT_BITS feedback bits into a word
// and hands each word out over a valid/ready handshake.
module lfsr_prng #(
  parameter int               WIDTH    = 7,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(7'b1100000),
  parameter logic [WIDTH-1:0] SEED     = '0,
  parameter int               OUT_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                seed_load,
  input  logic [WIDTH-1:0]    seed_in,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_word,
  output logic                bit_o,
  output logic [WIDTH-1:0]    state_o,
  output logic                lockup_o
);

  localparam int                CNT_W   = $clog2(OUT_BITS + 1);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(OUT_BITS);
  localparam logic [WIDTH-1:0]  ALL_ONE = '1;

  generate
    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
      $error("lfsr_prng: WIDTH must be in 3..32");
    end
    if (OUT_BITS < 1 || OUT_BITS > 32) begin : g_bad_out_bits
      $error("lfsr_prng: OUT_BITS must be in 1..32");
    end
    if (SEED == ALL_ONE) begin : g_bad_seed
      $error("lfsr_prng: SEED must not be the all-ones lock-up state");
    end
  endgenerate

  typedef enum logic {FILL, HOLD} fsm_t;

  fsm_t                r_fsm;
  logic [WIDTH-1:0]    r_state;
  logic [OUT_BITS-1:0] r_coll;
  logic [CNT_W-1:0]    r_count;
  logic                r_out_valid;
  logic [OUT_BITS-1:0] r_out_word;
  logic                r_lockup;

  logic                w_fb;
  logic [WIDTH-1:0]    w_step;
  logic [OUT_BITS:0]   w_coll_wide;
  logic [OUT_BITS-1:0] w_coll_shift;
  logic [CNT_W-1:0]    w_count_inc;
  logic                w_lock;
  logic                w_seed_in_lock;

  assign w_fb           = ~^(r_state & TAPS);
  assign w_step         = {r_state[WIDTH-2:0], w_fb};
  // Shift through a wider vector so OUT_BITS==1 needs no special slicing.
  assign w_coll_wide    = {r_coll, w_fb};
  assign w_coll_shift   = w_coll_wide[OUT_BITS-1:0];
  assign w_count_inc    = r_count + CNT_W'(1);
  assign w_lock         = (r_state == ALL_ONE);
  assign w_seed_in_lock = (seed_in == ALL_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= FILL;
      r_state     <= SEED;
      r_coll      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
      r_lockup    <= 1'b0;
    end else begin
      r_lockup <= 1'b0;
      if (seed_load) begin
        if (w_seed_in_lock) begin
          r_state  <= SEED;
          r_lockup <= 1'b1;
        end else begin
          r_state <= seed_in;
        end
        r_coll      <= '0;
        r_count     <= '0;
        r_out_valid <= 1'b0;
        r_fsm       <= FILL;
      end else if (w_lock) begin
        // Recover from the stuck state instead of stepping; word state untouched.
        r_state  <= SEED;
        r_lockup <= 1'b1;
      end else begin
        case (r_fsm)
          FILL: begin
            if (en) begin
              r_state <= w_step;
              r_coll  <= w_coll_shift;
              if (w_count_inc == LAST) begin
                r_out_word  <= w_coll_shift;
                r_out_valid <= 1'b1;
                r_count     <= '0;
                r_fsm       <= HOLD;
              end else begin
                r_count <= w_count_inc;
              end
            end
          end
          HOLD: begin
            if (out_ready) begin
              if (en) begin
                // Accepting cycle doubles as step 1 of the next word.
                r_state <= w_step;
                r_coll  <= w_coll_shift;
                if (OUT_BITS == 1) begin
                  r_out_word <= w_coll_shift;
                end else begin
                  r_out_valid <= 1'b0;
                  r_count     <= CNT_W'(1);
                  r_fsm       <= FILL;
                end
              end else begin
                r_out_valid <= 1'b0;
                r_fsm       <= FILL;
              end
            end
          end
        endcase
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_word  = r_out_word;
  assign bit_o     = w_fb;
  assign state_o   = r_state;
  assign lockup_o  = r_lockup;

endmodule

// File: tb/tb_lfsr_prng.sv
// Directed bench for lfsr_prng: a default 4-bit-word instance and a
// 1-bit-word instance sharing the same stimulus.
module tb_lfsr_prng;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       seed_load;
  logic [6:0] seed_in;
  logic       out_ready;

  logic       valid4, bit4, lock4;
  logic [3:0] word4;
  logic [6:0] state4;
  logic       valid1, bit1, lock1;
  logic [0:0] word1;
  logic [6:0] state1;

  int checks   = 0;
  int failures = 0;

  lfsr_prng #(.WIDTH(7), .TAPS(7'b1100000), .SEED(7'b0000000), .OUT_BITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .out_ready(out_ready), .out_valid(valid4), .out_word(word4), .bit_o(bit4),
    .state_o(state4), .lockup_o(lock4)
  );

  lfsr_prng #(.WIDTH(7), .TAPS(7'b1100000), .SEED(7'b0000000), .OUT_BITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .out_ready(out_ready), .out_valid(valid1), .out_word(word1), .bit_o(bit1),
    .state_o(state1), .lockup_o(lock1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    en = 1'b0; seed_load = 1'b0; seed_in = '0; out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (state4 !== 7'b0000000) begin failures++; $display("FAIL reset_state got=%b exp=0000000", state4); end
    checks++;
    if (valid4 !== 1'b0 || word4 !== 4'b0000) begin failures++; $display("FAIL reset_out got valid=%b word=%b exp 0/0000", valid4, word4); end
    checks++;
    if (lock4 !== 1'b0) begin failures++; $display("FAIL reset_lockup got=%b exp=0", lock4); end
    checks++;
    if (bit4 !== 1'b1) begin failures++; $display("FAIL reset_bit got=%b exp=1", bit4); end
    $display("reset: state=%b valid=%b word=%b", state4, valid4, word4);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    logic [6:0] exp_st [4];
    exp_st[0] = 7'b0000001; exp_st[1] = 7'b0000011;
    exp_st[2] = 7'b0000111; exp_st[3] = 7'b0001111;
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (state4 !== exp_st[i]) begin failures++; $display("FAIL fill_state%0d got=%b exp=%b", i, state4, exp_st[i]); end
    end
    checks++;
    if (valid4 !== 1'b1 || word4 !== 4'b1111) begin failures++; $display("FAIL first_word got valid=%b word=%b exp 1/1111", valid4, word4); end
    $display("fill: word=%b state=%b", word4, state4);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (valid4 !== 1'b0) begin failures++; $display("FAIL refill_valid%0d got=%b exp=0", i, valid4); end
    end
    tick();
    checks++;
    if (valid4 !== 1'b1 || word4 !== 4'b1101 || state4 !== 7'b1111101) begin
      failures++; $display("FAIL second_word got valid=%b word=%b state=%b exp 1/1101/1111101", valid4, word4, state4);
    end
    $display("fill: word=%b state=%b", word4, state4);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; en = 1'b1;
    do_reset();
    repeat (4) tick();
    checks++;
    if (valid4 !== 1'b1 || word4 !== 4'b1111) begin failures++; $display("FAIL bp_first got valid=%b word=%b exp 1/1111", valid4, word4); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (valid4 !== 1'b1 || word4 !== 4'b1111 || state4 !== 7'b0001111) begin
        failures++; $display("FAIL bp_hold%0d got valid=%b word=%b state=%b exp 1/1111/0001111", i, valid4, word4, state4);
      end
    end
    out_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (valid4 !== 1'b0) begin failures++; $display("FAIL bp_refill got valid=%b exp=0", valid4); end
    tick();
    checks++;
    if (valid4 !== 1'b1 || word4 !== 4'b1101) begin failures++; $display("FAIL bp_release got valid=%b word=%b exp 1/1101", valid4, word4); end
    out_ready = 1'b0;
    $display("backpressure: word=%b state=%b", word4, state4);
  endtask

  task automatic test_seed_load();
    seed_load = 1'b1; seed_in = 7'b0000001;
    tick();
    seed_load = 1'b0;
    checks++;
    if (valid4 !== 1'b0 || state4 !== 7'b0000001 || lock4 !== 1'b0) begin
      failures++; $display("FAIL seed_load got valid=%b state=%b lock=%b exp 0/0000001/0", valid4, state4, lock4);
    end
    out_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (valid4 !== 1'b0) begin failures++; $display("FAIL seed_refill got valid=%b exp=0", valid4); end
    tick();
    checks++;
    if (valid4 !== 1'b1 || word4 !== 4'b1111 || state4 !== 7'b0011111) begin
      failures++; $display("FAIL seed_resume got valid=%b word=%b state=%b exp 1/1111/0011111", valid4, word4, state4);
    end
    $display("seed_load: word=%b state=%b", word4, state4);
  endtask

  task automatic test_seed_lockup();
    seed_load = 1'b1; seed_in = 7'b1111111;
    tick();
    seed_load = 1'b0;
    checks++;
    if (state4 !== 7'b0000000 || lock4 !== 1'b1 || valid4 !== 1'b0) begin
      failures++; $display("FAIL lockup_seed got state=%b lock=%b valid=%b exp 0000000/1/0", state4, lock4, valid4);
    end
    tick();
    checks++;
    if (lock4 !== 1'b0 || state4 !== 7'b0000001) begin
      failures++; $display("FAIL lockup_pulse got lock=%b state=%b exp 0/0000001", lock4, state4);
    end
    $display("seed_lockup: state=%b lock=%b", state4, lock4);
  endtask

  task automatic test_en_toggle();
    out_ready = 1'b1; en = 1'b0;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      en = (i % 2 == 0);
      tick();
      if (i == 7) begin
        checks++;
        if (valid4 !== 1'b0) begin failures++; $display("FAIL toggle_early got valid=%b exp=0", valid4); end
      end
    end
    en = 1'b0;
    checks++;
    if (valid4 !== 1'b1 || word4 !== 4'b1111) begin failures++; $display("FAIL toggle_word got valid=%b word=%b exp 1/1111", valid4, word4); end
    $display("en_toggle: word=%b state=%b", word4, state4);
  endtask

  task automatic test_async_reset();
    en = 1'b1; out_ready = 1'b1;
    do_reset();
    repeat (2) tick();
    checks++;
    if (state4 !== 7'b0000011) begin failures++; $display("FAIL pre_reset got state=%b exp=0000011", state4); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state4 !== 7'b0000000 || valid4 !== 1'b0 || word4 !== 4'b0000 || lock4 !== 1'b0) begin
      failures++; $display("FAIL async_reset got state=%b valid=%b word=%b lock=%b", state4, valid4, word4, lock4);
    end
    $display("async_reset: state=%b valid=%b", state4, valid4);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [6:0] m;
    logic       fb;
    int         zero_hits;
    en = 1'b1; out_ready = 1'b1;
    do_reset();
    tick();
    checks++;
    if (valid1 !== 1'b1 || word1 !== 1'b1 || state1 !== 7'b0000001) begin
      failures++; $display("FAIL b2b_first got valid=%b word=%b state=%b exp 1/1/0000001", valid1, word1, state1);
    end
    m = 7'b0000001;
    zero_hits = 0;
    for (int i = 2; i <= 127; i++) begin
      fb = ~(m[6] ^ m[5]);
      m  = {m[5:0], fb};
      tick();
      checks++;
      if (valid1 !== 1'b1 || word1 !== fb || state1 !== m) begin
        failures++; $display("FAIL b2b_step%0d got valid=%b word=%b state=%b exp 1/%b/%b", i, valid1, word1, state1, fb, m);
      end
      if (i < 127 && state1 == 7'b0000000) zero_hits++;
    end
    checks++;
    if (state1 !== 7'b0000000 || zero_hits !== 0) begin
      failures++; $display("FAIL b2b_period got state=%b early_hits=%0d exp 0000000/0", state1, zero_hits);
    end
    $display("back_to_back: final state=%b early_hits=%0d", state1, zero_hits);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_backpressure();
    test_seed_load();
    test_seed_lockup();
    test_en_toggle();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_prng.md
Name: lfsr_prng

Overview:
- Parametrised XNOR-feedback Fibonacci LFSR pseudo-random generator. Successor to the fixed 7-bit generator.
- Adds a configurable width and tap mask, runtime seed loading, and lock-up detection with recovery.
- Assembles OUT_BITS successive feedback bits into a word and delivers it over a valid/ready handshake.
- Feeds game/visual logic that needs random words on demand, rather than a free-running bit.

Parameters:
- WIDTH, 7, LFSR register width; legal range 3..32.
- TAPS, 7'b1100000, WIDTH-bit tap mask; bit i set means state[i] feeds the XNOR.
- SEED, 0, WIDTH-bit reset and recovery state; must not be all-ones (elaboration-time assertion).
- OUT_BITS, 4, bits per output word; legal range 1..32.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- en  input  1  step enable; when low, the LFSR and collector freeze.
- seed_load  input  1  load seed_in into the LFSR this cycle.
- seed_in  input  WIDTH  runtime seed.
- out_ready  input  1  consumer accepts out_word.
- out_valid  output  1  out_word holds a complete word.
- out_word  output  OUT_BITS  random word; the first bit generated is the MSB.
- bit_o  output  1  current feedback bit (combinational).
- state_o  output  WIDTH  current LFSR state.
- lockup_o  output  1  one-cycle pulse when a lock-up state was rejected or recovered.

Behaviour:
- Reset (async assert, sync release): state=SEED, collector=0, count=0, FSM=FILL, out_valid=0, out_word=0, lockup_o=0.
- Feedback: fb = ~^(state & TAPS). Step: state <= {state[WIDTH-2:0], fb}. bit_o = fb.
- Lock-up state is all-ones (XNOR form).
  - A registered state of all-ones (e.g. via fault) is replaced by SEED on the next clock instead of stepping.
  - lockup_o pulses for that cycle.
- FSM FILL:
  - Each cycle with en=1: step, collector <= {collector[OUT_BITS-2:0], fb}, count++.
  - When the step makes count==OUT_BITS: out_word <= new collector, out_valid <= 1, count <= 0, go to HOLD.
- FSM HOLD:
  - out_valid=1; out_word stable; the LFSR does not step while out_ready=0 (no bits lost).
  - out_valid & out_ready & en: handshake completes and that same cycle performs step 1 of the next word.
    - OUT_BITS>1: out_valid <= 0, count=1, go to FILL.
    - OUT_BITS==1: stay in HOLD with the new word (one word per cycle).
  - out_valid & out_ready & !en: handshake completes, out_valid <= 0, go to FILL, no step.
- Throughput with out_ready held high and en=1: one word every OUT_BITS cycles. First out_valid appears OUT_BITS cycles after the first enabled cycle.
- seed_load has highest priority and overrides en and the handshake:
  - state <= seed_in, or SEED if seed_in is all-ones (lockup_o pulses in that case).
  - Collector cleared, count=0, out_valid <= 0, FSM=FILL. Any pending word is discarded.
- en low in FILL: all state holds. en has no effect on a held word's visibility.
- out_word changes only on entry to HOLD; it is never modified while out_valid=1 and out_ready=0.
- Reset mid-operation: immediate return to reset values regardless of FSM state.

Test Plan:
- Defaults, reset release, en=1, out_ready=1:
  - state_o follows 0000001, 0000011, 0000111, 0001111.
  - out_valid rises after 4 cycles with out_word=4'b1111.
  - Next word is 4'b1101, and state_o=1111101 at that point.
- Back-pressure: out_ready=0 for 10 cycles with the first word held -> out_word stays 4'b1111, state_o stays 0001111. Raising out_ready produces 4'b1101 four cycles later.
- seed_load with seed_in=7'b0000001 while in HOLD -> next cycle out_valid=0, state_o=0000001, lockup_o=0. Words resume 4 cycles later.
- seed_load with seed_in=7'b1111111 -> state_o=SEED (0000000), lockup_o high for exactly one cycle.
- en toggled 1/0 every cycle -> the word arrives after 8 cycles with the same value 4'b1111. rst_n pulsed low mid-FILL -> outputs return to reset values asynchronously.
- WIDTH=7, OUT_BITS=1, out_ready=1 -> out_valid is high every cycle after the first. The word stream equals bit_o delayed one cycle, with period 127 (maximal length).
